// File: rtl/etapa_resultado_alu.sv
// etapa_resultado_alu: ALU-to-memory skid-buffered result stage with NZCV flags register and condition evaluation
module etapa_resultado_alu #(
    parameter int n     = 32,
    parameter int REG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [n-1:0]     in_result,
    input  logic [3:0]       in_banderas,
    input  logic [REG_W-1:0] in_rd,
    input  logic             in_we,
    input  logic             in_set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [n-1:0]     out_result,
    output logic [REG_W-1:0] out_rd,
    output logic             out_we,
    output logic [3:0]       flags,
    input  logic [3:0]       cond,
    output logic             cond_pass
);
    typedef struct packed {
        logic [n-1:0]     result;
        logic [REG_W-1:0] rd;
        logic             we;
    } entry_t;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t     state_q, state_d;
    entry_t     main_q, main_d, skid_q, skid_d, in_e;
    logic [3:0] flags_q, flags_d;
    logic       in_xfer, out_xfer;
    logic       n_f, z_f, c_f, v_f;

    assign in_e     = {in_result, in_rd, in_we};
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   state_d = in_xfer ? ONE : EMPTY;
            ONE:     state_d = (in_xfer && !out_xfer) ? FULL : ((!in_xfer && out_xfer) ? EMPTY : ONE);
            FULL:    state_d = out_xfer ? ONE : FULL;
            default: state_d = EMPTY;
        endcase
    end

    // in_ready comes straight from the state register, so it never sees out_ready
    always_comb begin
        in_ready  = state_q != FULL;
        out_valid = state_q != EMPTY;
    end

    always_comb begin
        main_d  = main_q;
        skid_d  = skid_q;
        flags_d = (in_xfer && in_set_flags) ? in_banderas : flags_q;
        if (state_q == FULL && out_xfer)
            main_d = skid_q;
        else if (in_xfer && (state_q == EMPTY || out_xfer))
            main_d = in_e;
        else if (in_xfer)
            skid_d = in_e;
    end

    assign out_result = main_q.result;
    assign out_rd     = main_q.rd;
    assign out_we     = main_q.we;
    assign flags      = flags_q;

    assign {n_f, z_f, c_f, v_f} = flags_q;

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'h0: cond_pass = z_f;
            4'h1: cond_pass = !z_f;
            4'h2: cond_pass = c_f;
            4'h3: cond_pass = !c_f;
            4'h4: cond_pass = n_f;
            4'h5: cond_pass = !n_f;
            4'h6: cond_pass = v_f;
            4'h7: cond_pass = !v_f;
            4'h8: cond_pass = c_f && !z_f;
            4'h9: cond_pass = !c_f || z_f;
            4'hA: cond_pass = n_f == v_f;
            4'hB: cond_pass = n_f != v_f;
            4'hC: cond_pass = !z_f && (n_f == v_f);
            4'hD: cond_pass = z_f || (n_f != v_f);
            4'hE: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_etapa_resultado_alu.sv
// tb_etapa_resultado_alu: directed checks of buffering, backpressure, flags and condition codes
module tb_etapa_resultado_alu;
    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, in_we = 1'b0, in_set_flags = 1'b0;
    logic [31:0] in_result = '0, out_result;
    logic [3:0]  in_banderas = '0, in_rd = '0, out_rd, flags, cond = '0;
    logic        out_valid, out_ready = 1'b0, out_we, cond_pass;
    int          errs = 0, checks = 0;

    etapa_resultado_alu #(.n(32), .REG_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_banderas(in_banderas), .in_rd(in_rd),
        .in_we(in_we), .in_set_flags(in_set_flags), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
        .out_we(out_we), .flags(flags), .cond(cond), .cond_pass(cond_pass)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [31:0] r, input logic [3:0] rd, input logic we,
                        input logic [3:0] b, input logic sf);
        in_valid = 1'b1; in_result = r; in_rd = rd; in_we = we; in_banderas = b; in_set_flags = sf;
    endtask

    logic [3:0]  fl_pat [6] = '{4'b0000, 4'b1000, 4'b0001, 4'b1001, 4'b0110, 4'b0010};
    logic [15:0] exp_mask [6] = '{16'h56AA, 16'h6A9A, 16'h6A6A, 16'h565A, 16'h66A5, 16'h55A6};

    initial begin
        tick(); tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_flags", flags, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_rd", out_rd, 0);
        check("rst_out_we", out_we, 0);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", in_ready, 1);

        out_ready = 1'b1;
        send(32'd1, 4'd3, 1'b1, 4'b0, 1'b0);
        tick();
        check("stream1_valid", out_valid, 1);
        check("stream1_data", out_result, 1);
        check("stream1_rd", out_rd, 3);
        check("stream1_we", out_we, 1);
        check("stream1_ready", in_ready, 1);
        send(32'd2, 4'd4, 1'b0, 4'b0, 1'b0);
        tick();
        check("stream2_data", out_result, 2);
        check("stream2_rd", out_rd, 4);
        check("stream2_we", out_we, 0);
        check("stream2_ready", in_ready, 1);
        send(32'd3, 4'd5, 1'b1, 4'b0, 1'b0);
        tick();
        check("stream3_data", out_result, 3);
        check("stream3_ready", in_ready, 1);
        in_valid = 1'b0;
        tick();
        check("stream_drained", out_valid, 0);
        check("stream_hold", out_result, 3);

        out_ready = 1'b0;
        send(32'hA, 4'd1, 1'b1, 4'b0, 1'b0);
        tick();
        check("bp_one_data", out_result, 32'hA);
        check("bp_one_ready", in_ready, 1);
        send(32'hB, 4'd2, 1'b1, 4'b0, 1'b0);
        tick();
        check("bp_full_ready", in_ready, 0);
        check("bp_full_valid", out_valid, 1);
        check("bp_full_data", out_result, 32'hA);
        send(32'hC, 4'd7, 1'b1, 4'b1111, 1'b1);
        tick();
        check("bp_blocked_flags", flags, 0);
        check("bp_stable_data", out_result, 32'hA);
        check("bp_stable_rd", out_rd, 1);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("bp_drain_b", out_result, 32'hB);
        check("bp_drain_b_rd", out_rd, 2);
        check("bp_drain_valid", out_valid, 1);
        check("bp_drain_ready", in_ready, 1);
        tick();
        check("bp_empty", out_valid, 0);

        send(32'd0, 4'd0, 1'b1, 4'b0100, 1'b1);
        cond = 4'h0;
        #1;
        check("flag_same_cycle_eq", cond_pass, 0);
        tick();
        in_valid = 1'b0;
        #1;
        check("flag_updated", flags, 4'b0100);
        check("flag_eq", cond_pass, 1);
        cond = 4'h1;
        #1;
        check("flag_ne", cond_pass, 0);

        send(32'd5, 4'd0, 1'b1, 4'b1001, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        check("no_update_flags", flags, 4'b0100);

        for (int p = 0; p < 6; p++) begin
            send(32'd0, 4'd0, 1'b0, fl_pat[p], 1'b1);
            tick();
            in_valid = 1'b0;
            check($sformatf("sweep_flags_%b", fl_pat[p]), flags, {28'd0, fl_pat[p]});
            for (int c = 0; c < 16; c++) begin
                cond = 4'(c);
                #1;
                check($sformatf("cond_%b_%h", fl_pat[p], c), cond_pass, exp_mask[p][c]);
            end
            tick();
        end

        out_ready = 1'b0;
        send(32'h11, 4'd1, 1'b1, 4'b0100, 1'b1);
        tick();
        send(32'h22, 4'd2, 1'b1, 4'b0100, 1'b1);
        tick();
        in_valid = 1'b0;
        check("pre_rst_full", in_ready, 0);
        cond = 4'h0;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_flags", flags, 0);
        check("midrst_eq", cond_pass, 0);
        tick();
        rst = 1'b0;
        tick();
        check("midrst_release_ready", in_ready, 1);
        check("midrst_release_valid", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
